// File: rtl/shift.sv
// Serial-in, parallel-out shift register with shift enable and async active-low reset.
// Defining SHIFT_FILL_FLAG_EN adds a registered 'full' output (WIDTH bits accepted since reset).
module shift #(
    parameter int WIDTH      = 8,
    parameter bit SHIFT_LEFT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             in,
    output logic [WIDTH-1:0] out
`ifdef SHIFT_FILL_FLAG_EN
    ,
    output logic             full
`endif
);

    // Shift register stage. 'out' is the flop output itself, so there is no input-to-output path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out <= '0;
        end else if (we) begin
            if (SHIFT_LEFT) begin
                out <= {out[WIDTH-2:0], in};
            end else begin
                out <= {in, out[WIDTH-1:1]};
            end
        end
    end

`ifdef SHIFT_FILL_FLAG_EN
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] cnt;

    // Counter saturates at WIDTH; full is set on the same edge the count reaches WIDTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            full <= 1'b0;
        end else if (we && !full) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
                full <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_shift.sv
// Bench for shift: a left- and a right-shifting instance driven by the same stream,
// compared against a bit-history model and the directed values of the test plan.
module tb_shift;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         we;
    logic         in;
    logic [W-1:0] out_l;
    logic [W-1:0] out_r;
`ifdef SHIFT_FILL_FLAG_EN
    logic         full_l;
    logic         full_r;
`endif

    int checks = 0;
    int errors = 0;

    // Model state: every bit accepted since the last reset, oldest first.
    logic bit_q[$];
    logic [W-1:0] exp_q[$];

    shift #(.WIDTH(W), .SHIFT_LEFT(1'b1)) u_left (
        .clk (clk),
        .rst (rst),
        .we  (we),
        .in  (in),
        .out (out_l)
`ifdef SHIFT_FILL_FLAG_EN
        ,
        .full(full_l)
`endif
    );

    shift #(.WIDTH(W), .SHIFT_LEFT(1'b0)) u_right (
        .clk (clk),
        .rst (rst),
        .we  (we),
        .in  (in),
        .out (out_r)
`ifdef SHIFT_FILL_FLAG_EN
        ,
        .full(full_r)
`endif
    );

    // Clock block: 10 ns period, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within 100000 ns");
        $fatal(1, "timeout");
    end

    // Expected parallel word: newest bit at out[0] (left) or out[W-1] (right).
    function automatic logic [W-1:0] model_word(bit left);
        logic [W-1:0] w;
        int n;
        w = '0;
        n = bit_q.size();
        for (int i = 0; i < W; i++) begin
            if (i < n) begin
                if (left) w[i] = bit_q[n-1-i];
                else      w[W-1-i] = bit_q[n-1-i];
            end
        end
        return w;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        exp_q.push_back(model_word(1'b1));
        exp_q.push_back(model_word(1'b0));
        chk({tag, "_left"}, 64'(out_l), 64'(exp_q.pop_front()));
        chk({tag, "_right"}, 64'(out_r), 64'(exp_q.pop_front()));
`ifdef SHIFT_FILL_FLAG_EN
        chk({tag, "_full_l"}, 64'(full_l), 64'(bit_q.size() >= W));
        chk({tag, "_full_r"}, 64'(full_r), 64'(bit_q.size() >= W));
`endif
    endtask

    // Driver: apply inputs at the falling edge, update the model at the rising edge, sample 1 ns later.
    task automatic step(input logic we_v, input logic in_v);
        @(negedge clk);
        we = we_v;
        in = in_v;
        @(posedge clk);
        if (we_v) bit_q.push_back(in_v);
        #1;
    endtask

    // Reset pulse placed between edges; caller is 1 ns after a rising edge.
    task automatic async_reset();
        we = 1'b0;
        #2;
        rst = 1'b0;
        bit_q.delete();
        #1;
        chk("async_rst_left", 64'(out_l), 64'h0);
        chk("async_rst_right", 64'(out_r), 64'h0);
`ifdef SHIFT_FILL_FLAG_EN
        chk("async_rst_full", 64'(full_r), 64'h0);
`endif
        #2;
        rst = 1'b1;
    endtask

    logic [15:0] ovf_pattern;

    initial begin
        rst = 1'b0;
        we  = 1'b0;
        in  = 1'b0;

        // Power-up reset with clock running and random inputs.
        #6;
        for (int i = 0; i < 4; i++) begin
            chk("powerup_left", 64'(out_l), 64'h0);
            chk("powerup_right", 64'(out_r), 64'h0);
            we = 1'($urandom_range(0, 1));
            in = 1'($urandom_range(0, 1));
            #5;
        end
        we  = 1'b0;
        rst = 1'b1;
        bit_q.delete();

        // Basic shift: 1,0,1,1 then 0,0,1,1.
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("basic_0B", 64'(out_l), 64'h0B);
        chk_model("basic4");
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("basic_B3", 64'(out_l), 64'hB3);
        chk_model("basic8");

        // Hold with in toggling.
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'(i));
        end
        chk("hold_B3", 64'(out_l), 64'hB3);
        chk_model("hold");
        step(1'b1, 1'b1);
        chk("after_hold_67", 64'(out_l), 64'h67);

        // Overflow: 16 bits, only the last 8 survive.
        ovf_pattern = 16'b1010_0101_1100_0011;
        for (int i = 15; i >= 0; i--) begin
            step(1'b1, ovf_pattern[i]);
        end
        chk("overflow_C3", 64'(out_l), 64'hC3);
        chk_model("overflow");

        // Async reset mid-stream, then one bit.
        async_reset();
        step(1'b1, 1'b1);
        chk("post_rst_01", 64'(out_l), 64'h01);
        chk("post_rst_80", 64'(out_r), 64'h80);

        // Random stream with occasional async resets.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                async_reset();
            end else begin
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            chk_model("random");
        end

        // Direction and fill: 1 then seven 0s into the right-shifting instance.
        async_reset();
        step(1'b1, 1'b1);
        for (int i = 0; i < 7; i++) begin
`ifdef SHIFT_FILL_FLAG_EN
            chk("fill_not_full", 64'(full_r), 64'h0);
`endif
            step(1'b1, 1'b0);
        end
        chk("fill_right_01", 64'(out_r), 64'h01);
        chk("fill_left_80", 64'(out_l), 64'h80);
`ifdef SHIFT_FILL_FLAG_EN
        chk("fill_full", 64'(full_r), 64'h1);
`endif
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'(i));
`ifdef SHIFT_FILL_FLAG_EN
            chk("fill_full_hold", 64'(full_r), 64'h1);
`endif
        end
        chk("fill_hold_right", 64'(out_r), 64'h01);
        async_reset();
        chk_model("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift.md
Name: shift

Overview:
- Serial-in, parallel-out shift register with a write enable.
- Captures one serial bit per enabled clock edge and presents the last WIDTH captured bits on a parallel output.
- Used as a serial-to-parallel front end, e.g. a bit-stream deserializer feeding byte-wide logic.
- One clock domain, asynchronous active-low reset.

Parameters:
- WIDTH, 8: number of register stages and output width; legal range 2..64.
- SHIFT_LEFT, 1: 1 means the new bit enters at out[0] and older bits move toward out[WIDTH-1]. 0 means the new bit enters at out[WIDTH-1] and older bits move toward out[0].

Ports:
- clk  input  1  clock; all state changes on its rising edge, except reset.
- rst  input  1  reset; asynchronous assertion, active-low.
- we  input  1  shift enable; sampled on the rising clk edge.
- in  input  1  serial data bit; sampled on the rising clk edge when we=1.
- out  output  WIDTH  parallel register contents; driven directly from flops, no combinational path from any input.
- full  output  1  present only when SHIFT_FILL_FLAG_EN is defined (see Optional Feature).

Interface decisions:
- One clock; reset is asynchronous and active-low.
- Clock port is named clk and reset port is named rst.

Behaviour:
- Reset: rst=0 clears out to all zeros immediately, with no clock required. The register holds zero while rst=0, regardless of we and in. Reset release is synchronous to clk; the first shift can occur on the first rising edge at which rst=1.
- Shift with SHIFT_LEFT=1: on a rising edge with rst=1 and we=1, out becomes {out[WIDTH-2:0], in}.
- Shift with SHIFT_LEFT=0: on a rising edge with rst=1 and we=1, out becomes {in, out[WIDTH-1:1]}.
- Hold: on a rising edge with we=0, out keeps its value. in is ignored.
- Latency: a bit sampled at edge N is visible on out after edge N. It appears at the far end (out[WIDTH-1] when SHIFT_LEFT=1) after WIDTH-1 further enabled edges.
- Overflow: the bit shifted out of the far end is discarded. There is no wrap-around and no carry output.
- Enable gaps: disabled cycles do not count toward latency. Only enabled edges advance the data.
- Reset mid-operation: asserting rst=0 at any time, including between clock edges, clears out at once. Any partial word is lost.
- Unknown input: X/Z on in while we=1 is captured as-is; no masking. X on we must not corrupt out in synthesis; simulation behaviour is undefined.
- No glitches: out changes only on a rising clk edge or on reset assertion.

Optional Feature:
- Macro SHIFT_FILL_FLAG_EN.
- When defined:
  - Adds output port full (1 bit) and an internal fill counter of clog2(WIDTH+1) bits.
  - Reset sets the counter to 0 and full to 0.
  - Each enabled edge increments the counter, saturating at WIDTH.
  - full=1 exactly when the counter equals WIDTH, i.e. WIDTH bits have been accepted since reset. It stays 1 until the next reset.
  - full is registered, with no combinational path.
- When undefined: no full port, no counter; the module is a pure shift register.

Test Plan:
- Power-up reset, WIDTH=8: rst=0 for 25 ns with clk toggling and random in -> out=8'h00 throughout; out=8'h00 immediately after rst falls, even mid-cycle.
- Basic shift, SHIFT_LEFT=1: release rst, we=1, bits 1,0,1,1 on four edges -> out=8'h0B. Continue with 0,0,1,1 -> out=8'hB3.
- Hold: after out=8'hB3, we=0 for 6 edges with in toggling -> out stays 8'hB3. Then we=1 and one bit 1 -> out=8'h67.
- Overflow: we=1, shift 16 bits 1010_0101_1100_0011 -> out=8'hC3; the upper 8 bits are discarded.
- Async reset mid-stream: with out=8'hC3, pulse rst=0 for 3 ns between edges -> out=8'h00 within that window. The next enabled edge with in=1 -> out=8'h01.
- Direction and fill flag: SHIFT_LEFT=0 with SHIFT_FILL_FLAG_EN defined. Shift in 1 followed by seven 0s -> out=8'h01 and full rises after the 8th enabled edge. It stays 1 during we=0 cycles and clears on reset.
